// File: rtl/kgp_alu_pkg.sv
// Shared types and constants for the KGP-RISC ALU sequencers.
// Holds the nibble width, the sequencer state encoding and the slice-count helper.
package kgp_alu_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int nslice(input int width);
        return width / NIB;
    endfunction

endpackage

// File: rtl/serial_add_seq_lcu.sv
// 4-bit lookahead carry unit: all four carries come from p, g and cin in two logic levels.
// There is no ripple inside the slice.
module LCU (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] c
);

    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/serial_add_seq.sv
// Multi-cycle add/subtract sequencer: one LCU slice is reused once per nibble, LSB first.
// The carry is registered between slices, and valid/ready handshakes are used on both sides.
module serial_add_seq
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NSLICE = nslice(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb, sum_next;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [NIB-1:0]   sp, sg, sc, snib;
    logic             accept;

    // Slice select: a mux on idx feeds the single lookahead unit.
    always_comb begin
        sp       = opa[int'(idx)*NIB +: NIB] ^ opb[int'(idx)*NIB +: NIB];
        sg       = opa[int'(idx)*NIB +: NIB] & opb[int'(idx)*NIB +: NIB];
        snib     = sp ^ {sc[2:0], carry};
        sum_next = sum;
        sum_next[int'(idx)*NIB +: NIB] = snib;
    end

    LCU u_lcu (
        .p   (sp),
        .g   (sg),
        .cin (carry),
        .c   (sc)
    );

    // NOTE: every variable is given a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = RUN;
            end
            RUN: begin
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && start_valid;

    // NOTE: registers use non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin | sub;
            idx   <= '0;
        end else if (state == RUN) begin
            sum   <= sum_next;
            carry <= sc[3];
            idx   <= idx + 1'b1;
            // The flags come from the top slice. zero also sees the nibble written on this edge.
            if (idx == LAST) begin
                cout     <= sc[3];
                overflow <= sc[3] ^ sc[2];
                zero     <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: a reference add/sub model fills the queue when a request is accepted.
// Each result is popped and compared when res_valid rises.
module tb_serial_add_seq;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    serial_add_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin, input logic tsub);
        exp_t        e;
        logic [31:0] bv;
        logic [32:0] full;
        bv     = tsub ? ~tb_ : tb_;
        full   = {1'b0, ta} + {1'b0, bv} + {32'd0, (tsub | tcin)};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (ta[31] == bv[31]) && (full[31] != ta[31]);
        e.zero = (full[31:0] == 32'd0);
        return e;
    endfunction

    // These tasks start and end just after a falling edge.
    task automatic accept_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin, input logic tsub);
        a = ta; b = tb_; cin = tcin; sub = tsub;
        start_valid = 1'b1;
        sb.push_back(model(ta, tb_, tcin, tsub));
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%b exp=1", start_ready);
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic collect_result(input string name);
        int   lat = 0;
        exp_t e;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout res_valid got=%b exp=1", name, res_valid);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=8", name, lat);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty got=0 exp=1 entries", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (sum !== e.sum) begin
            failures++;
            $display("FAIL %s sum got=%h exp=%h", name, sum, e.sum);
        end
        checks++;
        if (cout !== e.cout) begin
            failures++;
            $display("FAIL %s cout got=%b exp=%b", name, cout, e.cout);
        end
        checks++;
        if (overflow !== e.ovf) begin
            failures++;
            $display("FAIL %s overflow got=%b exp=%b", name, overflow, e.ovf);
        end
        checks++;
        if (zero !== e.zero) begin
            failures++;
            $display("FAIL %s zero got=%b exp=%b", name, zero, e.zero);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake valid/ready got=%b%b exp=01", name, res_valid, start_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({start_ready, res_valid, cout, overflow, zero} !== 5'b10000 || sum !== 32'd0) begin
            failures++;
            $display("FAIL reset rdy/vld/cout/ovf/zero got=%b sum=%h exp=10000 sum=00000000",
                     {start_ready, res_valid, cout, overflow, zero}, sum);
        end
    endtask

    task automatic test_basic();
        logic [31:0] va[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'h8000_0000};
        logic [31:0] vb[6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7, 32'd5, 32'h0000_0001};
        logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            accept_op(va[i], vb[i], 1'b0, vs[i]);
            collect_result($sformatf("basic%0d", i));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            accept_op($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            collect_result($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        logic [2:0]  f0;
        int          lat = 0;
        exp_t        e;
        accept_op(32'h0000_00FF, 32'h0000_0F01, 1'b1, 1'b0);
        while (res_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL bp_first timeout res_valid got=%b exp=1", res_valid);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (sum !== e.sum) begin
            failures++;
            $display("FAIL bp_first sum got=%h exp=%h", sum, e.sum);
        end
        s0 = sum;
        f0 = {cout, overflow, zero};
        a = 32'hCAFE_0000; b = 32'h0000_BABE; cin = 1'b0; sub = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (sum !== s0 || {cout, overflow, zero} !== f0 || res_valid !== 1'b1 || start_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc%0d sum=%h flags=%b vld=%b rdy=%b exp sum=%h flags=%b vld=1 rdy=0",
                         i, sum, {cout, overflow, zero}, res_valid, start_ready, s0, f0);
            end
        end
        sb.push_back(model(a, b, cin, sub));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release rdy/vld got=%b%b exp=10", start_ready, res_valid);
        end
        @(negedge clk);
        start_valid = 1'b0;
        checks++;
        if (start_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept start_ready got=%b exp=0", start_ready);
        end
        collect_result("bp_second");
    endtask

    task automatic test_back_to_back();
        accept_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
        collect_result("b2b_0");
        accept_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        collect_result("b2b_1");
    endtask

    task automatic test_reset_mid_run();
        accept_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if (sb.size() > 0) void'(sb.pop_back());
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || sum !== 32'd0) begin
            failures++;
            $display("FAIL midrst rdy=%b vld=%b sum=%h exp rdy=1 vld=0 sum=00000000", start_ready, res_valid, sum);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_pulse cyc%0d res_valid got=%b exp=0", i, res_valid);
            end
        end
        accept_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        collect_result("midrst_after");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Multi-cycle 32-bit adder/subtractor sequencer for the KGP-RISC ALU. It reuses one 4-bit carry-lookahead slice (the `LCU` unit) over eight consecutive cycles, one nibble per cycle, with the carry registered between slices. It sits between the ALU decode stage (request side) and the writeback/flag logic (result side), and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Must be a multiple of 4.
- `NSLICE`, derived as WIDTH/4: number of slice cycles per operation.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  block can accept a request; high only in IDLE.
- `a`  in  WIDTH  operand A; sampled on the accept edge.
- `b`  in  WIDTH  operand B; sampled on the accept edge.
- `cin`  in  1  carry-in; ignored when `sub`=1.
- `sub`  in  1  1 = compute A−B (B inverted, carry-in forced to 1).
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `sum` == 0.

## Operation
- States are IDLE, RUN and DONE.
- **Accept:** occurs in IDLE when `start_valid`=1 and `start_ready`=1. On that edge:
  - latch `a` into `opa`;
  - latch `b ^ {WIDTH{sub}}` into `opb`;
  - set `carry` to `cin | sub`;
  - clear `idx` to 0;
  - go to RUN.
- **RUN, each cycle, for slice k = `idx`:**
  - p = opa[4k+3:4k] ^ opb[4k+3:4k]
  - g = opa[4k+3:4k] & opb[4k+3:4k]
  - The slice computes c[3:0] from p, g and `carry`.
  - sum[4k+3:4k] <= p ^ {c[2:0], carry}
  - `carry` <= c[3]
  - `idx` <= idx+1
- **End of RUN:** on the edge where `idx`=NSLICE−1:
  - `cout` <= c[3]
  - `overflow` <= c[3] ^ c[2]
  - `zero` <= (the final sum word == 0), including the nibble written on this edge
  - go to DONE.
- **DONE:** `res_valid`=1. All result outputs are held stable until `res_ready`=1, then the block returns to IDLE.
  - There is no accept in DONE. `start_ready` is 0 there.
- **Masking:** `start_valid` is ignored outside IDLE. `res_ready` is ignored outside DONE.
- **Stale bits:** `sum` bits not yet written in the current operation keep stale values. They are only meaningful while `res_valid`=1.

## Timing
- **Reset (rst_n=0 at an edge):**
  - state=IDLE, idx=0, carry=0;
  - `sum`=0, `cout`=0, `overflow`=0, `zero`=0, `res_valid`=0;
  - `start_ready` reads 1 from the first cycle after reset.
- **Reset mid-operation:** in RUN or DONE, reset aborts the operation. The partial result is discarded and the block re-enters IDLE with the reset values above. No `res_valid` pulse is produced for the aborted operation.
- **Latency:** if the accept edge is E0, `res_valid` rises after edge E0+NSLICE (8 edges for WIDTH=32).
- **Throughput:** at most one operation per NSLICE+2 cycles, because a DONE→IDLE cycle is required before the next accept.
- `start_ready` and `res_valid` are decoded from state only. They have no combinational path from `start_valid` or `res_ready`.
- **Back-to-back:** result handshake at edge D puts the block in IDLE in cycle D+1. The next accept can occur at edge D+1.
- **Critical path:** one 4-bit lookahead slice plus XOR. No carry chain longer than 4 bits exists in a single cycle.

## Structure
- **Package `kgp_alu_pkg`:**
  - state enum {IDLE, RUN, DONE};
  - `NIB` = 4;
  - a function returning NSLICE for a given WIDTH.
- **Sub-module:** one instance of the existing 4-bit lookahead carry unit `LCU` (ports p, g, cin, c).
  - Slice select is a mux on `idx`.
  - No other sub-modules.

## Test plan
- **Basic add:** a=0x00000001, b=0x00000001, cin=0, sub=0 → sum=0x00000002, cout=0, overflow=0, zero=0. `res_valid` rises exactly 8 edges after accept.
- **Full carry ripple:** a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, cout=1, zero=1, overflow=0. The carry must cross all 8 slices.
- **Signed overflow:** a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, overflow=1, cout=0.
- **Subtract:**
  - a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=7, b=5, sub=1 → sum=0x00000002, cout=1.
  - a=0x80000000, b=1, sub=1 → overflow=1.
- **Backpressure:** hold `res_ready`=0 for 5 cycles after `res_valid` rises, with `start_valid`=1 throughout.
  - Outputs stay stable and `start_ready` stays 0.
  - After the handshake, the new request is accepted on the next edge and its result is correct.
- **Reset mid-RUN:** pulse `rst_n`=0 for one edge at idx=3.
  - The next cycle shows IDLE, `res_valid`=0, `sum`=0.
  - A following op a=0x12345678, b=0x11111111 → sum=0x23456789.
